// File: rtl/calc_defs.sv
// rtl/calc_defs.sv - shared op codes, state encoding and limits for the calculator engine
// Purpose : constants and types shared by calc_engine and calc_alu.
// Contents: op codes, FSM state enum, MAX_VALUE, arithmetic-op helper.
package calc_defs;

   localparam logic [3:0] OP_NONE  = 4'h0;
   localparam logic [3:0] OP_EQUAL = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_SUB   = 4'h3;
   localparam logic [3:0] OP_MUL   = 4'h4;
   localparam logic [3:0] OP_CLEAR = 4'h5;

   localparam int MAX_VALUE = 9999;

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      OP_WAIT = 3'd1,
      ENTER_B = 3'd2,
      RESULT  = 3'd3,
      ERROR   = 3'd4
   } state_t;

   function automatic logic is_arith_op(input logic [3:0] c);
      return (c == OP_ADD) || (c == OP_SUB) || (c == OP_MUL);
   endfunction

endpackage

// File: rtl/calc_engine_if.sv
// rtl/calc_engine_if.sv - classifier-to-engine event bus and engine-to-display outputs
// Purpose : bundles the key events and display outputs of calc_engine.
// Signals : code, new_value, new_op, equal_pressed (classifier -> engine);
//           display, pending_op, error (engine -> display stage).
// Modports: master = classifier/display side, slave = calc_engine.
interface calc_engine_if #(
   parameter int WIDTH = 16
);
   logic [3:0]       code;
   logic             new_value;
   logic             new_op;
   logic             equal_pressed;
   logic [WIDTH-1:0] display;
   logic [3:0]       pending_op;
   logic             error;

   modport master (
      output code, new_value, new_op, equal_pressed,
      input  display, pending_op, error
   );

   modport slave (
      input  code, new_value, new_op, equal_pressed,
      output display, pending_op, error
   );
endinterface

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational add/sub/mul with range check
// Purpose : computes i_a op i_b and flags results outside 0..MAX_VALUE.
// Ports   : i_a, i_b (WIDTH operands), i_op (op code),
//           o_result (WIDTH result), o_err (out of range / negative).
module calc_alu
   import calc_defs::*;
#(
   parameter int WIDTH     = 16,
   parameter int MAX_VALUE = calc_defs::MAX_VALUE
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_op,
   output logic [WIDTH-1:0] o_result,
   output logic             o_err
);

   localparam logic [2*WIDTH-1:0] MAX_W = (2*WIDTH)'(MAX_VALUE);

   logic [2*WIDTH-1:0] w_a;
   logic [2*WIDTH-1:0] w_b;
   logic [2*WIDTH-1:0] w_raw;
   logic               w_neg;

   assign w_a = {{WIDTH{1'b0}}, i_a};
   assign w_b = {{WIDTH{1'b0}}, i_b};

   // Double-width arithmetic so the multiply product is range-checked before truncation.
   always_comb begin
      w_raw = '0;
      w_neg = 1'b0;
      case (i_op)
         OP_ADD: w_raw = w_a + w_b;
         OP_SUB: begin
            w_raw = w_a - w_b;
            w_neg = (i_b > i_a);
         end
         OP_MUL: w_raw = w_a * w_b;
         default: w_raw = '0;
      endcase
   end

   assign o_err    = w_neg || (w_raw > MAX_W);
   assign o_result = w_raw[WIDTH-1:0];

endmodule

// File: rtl/calc_engine.sv
// rtl/calc_engine.sv - decimal operand entry and left-to-right expression evaluation
// Purpose : builds operands from digit strobes, holds the pending operation,
//           evaluates chained expressions and reports range errors.
// Ports   : clock, reset (async, active-high); bus (calc_engine_if.slave):
//           code/new_value/new_op/equal_pressed in, display/pending_op/error out.
module calc_engine
   import calc_defs::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4,
   parameter int MAX_VALUE  = calc_defs::MAX_VALUE
) (
   input  logic          clock,
   input  logic          reset,
   calc_engine_if.slave  bus
);

   localparam int CW = $clog2(MAX_DIGITS + 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_opnd_a;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_pending_op;
   logic [CW-1:0]    r_count;

   logic             w_clear;
   logic             w_equal;
   logic             w_op;
   logic             w_digit;
   logic             w_room;
   logic [WIDTH-1:0] w_digit_val;
   logic [WIDTH-1:0] w_acc_app;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_err;
   logic [WIDTH-1:0] w_display;
   logic             w_error;

   // One event per cycle: clear > equal > op strobe > digit. Any new_op strobe
   // claims the cycle even when its code is not a usable operation.
   assign w_clear = bus.new_op && (bus.code == OP_CLEAR);
   assign w_equal = !w_clear && bus.equal_pressed;
   assign w_op    = !w_clear && !bus.equal_pressed && bus.new_op && is_arith_op(bus.code);
   assign w_digit = !w_clear && !bus.equal_pressed && !bus.new_op && bus.new_value
                    && (bus.code <= 4'd9);

   assign w_room      = (r_count < CW'(MAX_DIGITS));
   assign w_digit_val = {{(WIDTH-4){1'b0}}, bus.code};
   assign w_acc_app   = r_acc * WIDTH'(10) + w_digit_val;

   calc_alu #(
      .WIDTH     (WIDTH),
      .MAX_VALUE (MAX_VALUE)
   ) u_alu (
      .i_a      (r_opnd_a),
      .i_b      (r_acc),
      .i_op     (r_pending_op),
      .o_result (w_alu_res),
      .o_err    (w_alu_err)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ENTER_A;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      if (w_clear) begin
         w_state_next = ENTER_A;
      end else begin
         case (r_state)
            ENTER_A: begin
               if (w_op)         w_state_next = OP_WAIT;
               else if (w_equal) w_state_next = RESULT;
            end
            OP_WAIT: if (w_digit) w_state_next = ENTER_B;
            ENTER_B: begin
               if (w_op)         w_state_next = w_alu_err ? ERROR : OP_WAIT;
               else if (w_equal) w_state_next = w_alu_err ? ERROR : RESULT;
            end
            RESULT: begin
               if (w_digit)   w_state_next = ENTER_A;
               else if (w_op) w_state_next = OP_WAIT;
            end
            default: w_state_next = r_state;
         endcase
      end
   end

   // Operand, result and pending-op registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset || w_clear) begin
         r_acc        <= '0;
         r_opnd_a     <= '0;
         r_result     <= '0;
         r_pending_op <= OP_NONE;
         r_count      <= '0;
      end else begin
         case (r_state)
            ENTER_A, ENTER_B: begin
               if (w_digit && w_room) begin
                  r_acc   <= w_acc_app;
                  r_count <= r_count + CW'(1);
               end else if (w_op && r_state == ENTER_A) begin
                  r_opnd_a     <= r_acc;
                  r_pending_op <= bus.code;
                  r_acc        <= '0;
                  r_count      <= '0;
               end else if (w_op && !w_alu_err) begin
                  r_opnd_a     <= w_alu_res;
                  r_pending_op <= bus.code;
                  r_acc        <= '0;
                  r_count      <= '0;
               end else if (w_equal && r_state == ENTER_A) begin
                  r_result <= r_acc;
               end else if (w_equal && !w_alu_err) begin
                  r_result     <= w_alu_res;
                  r_pending_op <= OP_NONE;
               end
            end
            OP_WAIT: begin
               if (w_op) begin
                  r_pending_op <= bus.code;
               end else if (w_digit) begin
                  r_acc   <= w_digit_val;
                  r_count <= CW'(1);
               end
            end
            RESULT: begin
               if (w_digit) begin
                  r_acc   <= w_digit_val;
                  r_count <= CW'(1);
               end else if (w_op) begin
                  r_opnd_a     <= r_result;
                  r_pending_op <= bus.code;
                  r_acc        <= '0;
                  r_count      <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode
   always_comb begin
      w_display = '0;
      w_error   = 1'b0;
      case (r_state)
         ENTER_A, ENTER_B: w_display = r_acc;
         OP_WAIT:          w_display = r_opnd_a;
         RESULT:           w_display = r_result;
         ERROR:            w_error   = 1'b1;
         default:          w_display = '0;
      endcase
   end

   assign bus.display    = w_display;
   assign bus.error      = w_error;
   assign bus.pending_op = r_pending_op;

endmodule

// File: tb/tb_calc_engine.sv
// tb/tb_calc_engine.sv - directed self-checking bench for calc_engine
module tb_calc_engine;
   import calc_defs::*;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;

   calc_engine_if #(.WIDTH(16)) bus ();

   calc_engine #(
      .WIDTH      (16),
      .MAX_DIGITS (4),
      .MAX_VALUE  (9999)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk(input string tag, input int d, input int p, input int e);
      check_eq({tag, ".display"}, 32'(bus.display), d);
      check_eq({tag, ".pending_op"}, 32'(bus.pending_op), p);
      check_eq({tag, ".error"}, 32'(bus.error), e);
   endtask

   // Called at a falling edge: drive for one full cycle, release at the next falling edge.
   task automatic ev(input logic nv, input logic no, input logic eq, input logic [3:0] c);
      bus.code          = c;
      bus.new_value     = nv;
      bus.new_op        = no;
      bus.equal_pressed = eq;
      @(negedge clock);
      bus.new_value     = 1'b0;
      bus.new_op        = 1'b0;
      bus.equal_pressed = 1'b0;
   endtask

   task automatic dig(input logic [3:0] d);
      ev(1'b1, 1'b0, 1'b0, d);
   endtask

   task automatic opk(input logic [3:0] c);
      ev(1'b0, 1'b1, 1'b0, c);
   endtask

   task automatic eqk();
      ev(1'b0, 1'b0, 1'b1, 4'h0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.code = 4'h0;
      bus.new_value = 1'b0;
      bus.new_op = 1'b0;
      bus.equal_pressed = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("reset", 0, 0, 0);

      // 12 + 34 =
      dig(1);        chk("t1.d1", 1, 0, 0);
      dig(2);        chk("t1.d2", 12, 0, 0);
      opk(OP_ADD);   chk("t1.add", 12, 2, 0);
      dig(3);        chk("t1.d3", 3, 2, 0);
      dig(4);        chk("t1.d4", 34, 2, 0);
      eqk();         chk("t1.eq", 46, 0, 0);
      eqk();         chk("t1.eq_ignored", 46, 0, 0);

      // 7 * 8 = then - 6 = chained from RESULT
      opk(OP_CLEAR); chk("t2.clr", 0, 0, 0);
      dig(7); opk(OP_MUL); dig(8);
      eqk();         chk("t2.mul", 56, 0, 0);
      opk(OP_SUB);   chk("t2.sub", 56, 3, 0);
      dig(6);        chk("t2.d6", 6, 3, 0);
      eqk();         chk("t2.eq", 50, 0, 0);

      // 2 + 3 * 4 = evaluated left to right
      opk(OP_CLEAR);
      dig(2); opk(OP_ADD); dig(3);
      opk(OP_MUL);   chk("t3.chain", 5, 4, 0);
      dig(4);
      eqk();         chk("t3.eq", 20, 0, 0);

      // digit limit, overflow error, sticky error, clear
      opk(OP_CLEAR);
      dig(1); dig(2); dig(3); dig(4);
      chk("t4.d4", 1234, 0, 0);
      dig(5);        chk("t4.drop", 1234, 0, 0);
      opk(OP_MUL);   chk("t4.mul", 1234, 4, 0);
      dig(9);
      eqk();
      check_eq("t4.ovf.display", 32'(bus.display), 0);
      check_eq("t4.ovf.error", 32'(bus.error), 1);
      dig(3);
      check_eq("t4.err_dig.display", 32'(bus.display), 0);
      check_eq("t4.err_dig.error", 32'(bus.error), 1);
      opk(OP_ADD);
      check_eq("t4.err_op.error", 32'(bus.error), 1);
      eqk();
      check_eq("t4.err_eq.display", 32'(bus.display), 0);
      check_eq("t4.err_eq.error", 32'(bus.error), 1);
      opk(OP_CLEAR); chk("t4.clr", 0, 0, 0);
      dig(7);        chk("t4.fresh", 7, 0, 0);

      // negative result, then clear coinciding with a digit strobe
      opk(OP_CLEAR);
      dig(5); opk(OP_SUB); dig(9);
      eqk();
      check_eq("t5.neg.display", 32'(bus.display), 0);
      check_eq("t5.neg.error", 32'(bus.error), 1);
      ev(1'b1, 1'b1, 1'b0, OP_CLEAR); chk("t5.clr_vs_digit", 0, 0, 0);
      dig(8);        chk("t5.d8", 8, 0, 0);
      ev(1'b1, 1'b1, 1'b0, OP_CLEAR); chk("t5.clr_vs_digit2", 0, 0, 0);

      // range boundary: 99 * 101 = 9999 is legal, +1 is not
      dig(9); dig(9); opk(OP_MUL); dig(1); dig(0); dig(1);
      eqk();         chk("b.max", 9999, 0, 0);
      opk(OP_ADD); dig(1);
      eqk();
      check_eq("b.max_plus1.error", 32'(bus.error), 1);
      opk(OP_CLEAR);

      // ignored codes, equal in OP_WAIT, equal beats op
      dig(4);
      dig(4'd12);    chk("b.bad_digit", 4, 0, 0);
      opk(4'h7);     chk("b.bad_op", 4, 0, 0);
      opk(OP_ADD);   chk("b.opwait", 4, 2, 0);
      eqk();         chk("b.opwait_eq", 4, 2, 0);
      dig(6);
      ev(1'b0, 1'b1, 1'b1, OP_MUL); chk("b.eq_beats_op", 10, 0, 0);

      // asynchronous reset mid-entry
      opk(OP_CLEAR);
      dig(4); dig(2); chk("t6.d42", 42, 0, 0);
      #2 reset = 1'b1;
      #1;
      check_eq("t6.async.display", 32'(bus.display), 0);
      check_eq("t6.async.error", 32'(bus.error), 0);
      #1 reset = 1'b0;
      @(negedge clock);
      dig(3);        chk("t6.d3", 3, 0, 0);
      eqk();         chk("t6.eq", 3, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
